// File: rtl/simon_serial_core.sv
// simon_serial_core
//   Bit-serial SIMON block encryptor with a 2N-bit block, an M*N-bit key and
//   T rounds. Each RUN cycle does one full round and one key-schedule step.
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous, active-low reset
//   data_in    : serial plaintext / key bit
//   data_rdy   : command, 00 idle, 01 shift plaintext bit, 10 shift key bit, 11 start
//   debug_port : sampled at start; 1 = output phase streams the master key
//   cipher_out : serial output bit (registered, 0 whenever valid is low)
//   valid      : high for each cipher_out bit of the output phase
//   busy       : high while running rounds or streaming output
module simon_serial_core #(
  parameter int              N        = 16,
  parameter int              M        = 4,
  parameter int              T        = 32,
  parameter logic [61:0]     Z_SEQ    = 62'b11111010001001010110000111001101111101000100101011000011100110,
  parameter bit              KEY_LOCK = 1'b0,
  parameter logic [M*N-1:0]  KEY_INIT = '0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_in,
  input  logic [1:0] data_rdy,
  input  logic       debug_port,
  output logic       cipher_out,
  output logic       valid,
  output logic       busy
);

  localparam int BW = 2 * N;
  localparam int KW = M * N;
  localparam int OW = $clog2(BW);
  localparam int KI = $clog2(KW);
  localparam logic [N-1:0] C3 = N'(3);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OUT} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   blk_q, blk_d;
  logic [KW-1:0]   mkey_q, mkey_d;
  logic [N-1:0]    wkey_q [M];
  logic [N-1:0]    wkey_d [M];
  logic [6:0]      rcnt_q, rcnt_d;
  logic [OW-1:0]   ocnt_q, ocnt_d;
  logic            dbg_q, dbg_d;
  logic            cipher_out_q, cipher_out_d;
  logic            valid_q, valid_d;

  function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int s);
    return (v << s) | (v >> (N - s));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int s);
    return (v >> s) | (v << (N - s));
  endfunction

  // Round and key-schedule datapath
  logic [N-1:0] x_cur, y_cur, x_new;
  logic [N-1:0] ks_tmp, key_new;
  logic [5:0]   zidx;
  logic         z_bit;
  logic [KI-1:0] kidx;

  always_comb begin
    x_cur = blk_q[BW-1:N];
    y_cur = blk_q[N-1:0];
    x_new = y_cur ^ (rol(x_cur, 1) & rol(x_cur, 8)) ^ rol(x_cur, 2) ^ wkey_q[0];

    // rcnt never exceeds 126, so a single conditional subtract gives mod 62.
    zidx  = (rcnt_q >= 7'd62) ? 6'(rcnt_q - 7'd62) : rcnt_q[5:0];
    // z[0] lives in the MSB of Z_SEQ.
    z_bit = Z_SEQ[6'd61 - zidx];

    ks_tmp = ror(wkey_q[M-1], 3);
    if (M == 4) ks_tmp = ks_tmp ^ wkey_q[1];
    ks_tmp  = ks_tmp ^ ror(ks_tmp, 1);
    key_new = ~wkey_q[0] ^ ks_tmp ^ {{(N-1){1'b0}}, z_bit} ^ C3;

    // Debug stream walks the master key from its MSB downward.
    kidx = KI'(KW - 1) - KI'(ocnt_q);
  end

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    blk_d        = blk_q;
    mkey_d       = mkey_q;
    wkey_d       = wkey_q;
    rcnt_d       = rcnt_q;
    ocnt_d       = ocnt_q;
    dbg_d        = dbg_q;
    cipher_out_d = 1'b0;
    valid_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        case (data_rdy)
          2'b01: blk_d = {blk_q[BW-2:0], data_in};
          2'b10: if (!KEY_LOCK) mkey_d = {mkey_q[KW-2:0], data_in};
          2'b11: begin
            for (int i = 0; i < M; i++) wkey_d[i] = mkey_q[i*N +: N];
            dbg_d   = debug_port;
            rcnt_d  = '0;
            state_d = S_RUN;
          end
          default: ;
        endcase
      end

      S_RUN: begin
        blk_d = {x_new, x_cur};
        for (int i = 0; i < M - 1; i++) wkey_d[i] = wkey_q[i+1];
        wkey_d[M-1] = key_new;
        rcnt_d = rcnt_q + 7'd1;
        if (rcnt_q == 7'(T - 1)) begin
          state_d = S_OUT;
          ocnt_d  = '0;
        end
      end

      S_OUT: begin
        valid_d      = 1'b1;
        cipher_out_d = dbg_q ? mkey_q[kidx] : blk_q[BW-1];
        // Full rotation over 2N cycles leaves the ciphertext in place.
        blk_d  = {blk_q[BW-2:0], blk_q[BW-1]};
        ocnt_d = ocnt_q + 1'b1;
        if (ocnt_q == OW'(BW - 1)) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      blk_q        <= '0;
      mkey_q       <= KEY_INIT;
      for (int i = 0; i < M; i++) wkey_q[i] <= '0;
      rcnt_q       <= '0;
      ocnt_q       <= '0;
      dbg_q        <= 1'b0;
      cipher_out_q <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      blk_q        <= blk_d;
      mkey_q       <= mkey_d;
      for (int i = 0; i < M; i++) wkey_q[i] <= wkey_d[i];
      rcnt_q       <= rcnt_d;
      ocnt_q       <= ocnt_d;
      dbg_q        <= dbg_d;
      cipher_out_q <= cipher_out_d;
      valid_q      <= valid_d;
    end
  end

  assign cipher_out = cipher_out_q;
  assign valid      = valid_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_simon_serial_core.sv
module tb_simon_serial_core;

  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;

  // Instance 0: Simon32/64 default, 1: key locked at zero,
  // 2: Simon48/72, 3: Simon64/128.
  int nn [4] = '{16, 16, 24, 32};
  int mm [4] = '{4, 4, 3, 4};
  int tt [4] = '{32, 32, 36, 44};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       data_in = 1'b0;
  logic [1:0] data_rdy = 2'b00;
  logic       debug_port = 1'b0;
  int         sel = 0;
  logic [1:0] rdy [4];
  logic [3:0] co_w, vl_w, by_w;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) rdy[i] = (sel == i) ? data_rdy : 2'b00;
  end

  simon_serial_core u_d0 (
    .clk(clk), .reset(reset), .data_in(data_in), .data_rdy(rdy[0]), .debug_port(debug_port),
    .cipher_out(co_w[0]), .valid(vl_w[0]), .busy(by_w[0]));

  simon_serial_core #(.KEY_LOCK(1'b1), .KEY_INIT(64'h0)) u_d1 (
    .clk(clk), .reset(reset), .data_in(data_in), .data_rdy(rdy[1]), .debug_port(debug_port),
    .cipher_out(co_w[1]), .valid(vl_w[1]), .busy(by_w[1]));

  simon_serial_core #(.N(24), .M(3), .T(36), .Z_SEQ(Z0)) u_d2 (
    .clk(clk), .reset(reset), .data_in(data_in), .data_rdy(rdy[2]), .debug_port(debug_port),
    .cipher_out(co_w[2]), .valid(vl_w[2]), .busy(by_w[2]));

  simon_serial_core #(.N(32), .M(4), .T(44), .Z_SEQ(Z3)) u_d3 (
    .clk(clk), .reset(reset), .data_in(data_in), .data_rdy(rdy[3]), .debug_port(debug_port),
    .cipher_out(co_w[3]), .valid(vl_w[3]), .busy(by_w[3]));

  // Reference SIMON: textbook key expansion into a table, then T rounds.
  function automatic logic [31:0] m_rol(input logic [31:0] v, input int s, input int n,
                                        input logic [31:0] mask);
    return ((v << s) | (v >> (n - s))) & mask;
  endfunction

  function automatic logic [63:0] simon_model(input int n, input int m, input int t,
                                              input logic [61:0] z, input logic [127:0] key,
                                              input logic [63:0] pt);
    logic [31:0] mask, x, y, tmp;
    logic [31:0] k [128];
    mask = (n == 32) ? 32'hffff_ffff : ((32'd1 << n) - 32'd1);
    for (int i = 0; i < m; i++) k[i] = 32'(key >> (i * n)) & mask;
    for (int i = m; i < t; i++) begin
      tmp = m_rol(k[i-1], n - 3, n, mask);
      if (m == 4) tmp = tmp ^ k[i-3];
      tmp = tmp ^ m_rol(tmp, n - 1, n, mask);
      k[i] = (~k[i-m] ^ tmp ^ 32'(z[61 - ((i - m) % 62)]) ^ 32'd3) & mask;
    end
    x = 32'(pt >> n) & mask;
    y = 32'(pt) & mask;
    for (int i = 0; i < t; i++) begin
      tmp = x;
      x = y ^ (m_rol(x, 1, n, mask) & m_rol(x, 8, n, mask)) ^ m_rol(x, 2, n, mask) ^ k[i];
      y = tmp;
    end
    return (64'(x) << n) | 64'(y);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int id, input logic [159:0] key, input int kbits,
                      input logic [63:0] pt, input int pbits);
    sel = id;
    for (int i = kbits - 1; i >= 0; i--) begin data_rdy = 2'b10; data_in = key[i]; tick(); end
    for (int i = pbits - 1; i >= 0; i--) begin data_rdy = 2'b01; data_in = pt[i]; tick(); end
    data_rdy = 2'b00;
    data_in  = 1'b0;
  endtask

  // One start-to-idle transaction, measuring busy/valid timing and the stream.
  task automatic run_op(input int id, input bit dbg, input bit noise, input bit skip_start,
                        input bit chain, input logic [63:0] exp, input string tag);
    int n, t, first_v, vlen, blen, zbad;
    logic [63:0] s;
    n = nn[id]; t = tt[id];
    first_v = -1; vlen = 0; blen = 0; zbad = 0; s = '0;
    sel = id;
    if (!skip_start) begin
      data_rdy = 2'b11; debug_port = dbg;
      tick();
    end
    data_rdy = 2'b00; debug_port = 1'b0;
    if (by_w[id] === 1'b1) blen++;
    for (int c = 1; c <= t + 2 * n; c++) begin
      if (noise && c >= 2 && c < 12) begin data_rdy = 2'b01; data_in = 1'b1; end
      else if (noise && c >= 12 && c < 22) begin data_rdy = 2'b10; data_in = 1'b1; end
      else if (noise && c == 22) data_rdy = 2'b11;
      else data_rdy = 2'b00;
      debug_port = noise ? ~dbg : 1'b0;
      tick();
      if (by_w[id] === 1'b1) blen++;
      if (vl_w[id] === 1'b1) begin
        if (first_v < 0) first_v = c;
        vlen++;
        s = {s[62:0], co_w[id]};
      end else if (co_w[id] !== 1'b0) zbad++;
    end
    data_in = 1'b0; debug_port = 1'b0;
    data_rdy = chain ? 2'b11 : 2'b00;
    tick();
    data_rdy = 2'b00;
    $display("[TB] %s id=%0d dbg=%0d stream=%0h first_valid=%0d valid_len=%0d busy_len=%0d",
             tag, id, dbg, s, first_v, vlen, blen);
    check({tag, " stream"}, s, exp);
    check({tag, " first_valid"}, 64'(first_v), 64'(t + 1));
    check({tag, " valid_len"}, 64'(vlen), 64'(2 * n));
    check({tag, " busy_len"}, 64'(blen), 64'(t + 2 * n));
    check({tag, " out_zero"}, 64'(zbad), 64'd0);
    check({tag, " valid_end"}, 64'(vl_w[id]), 64'd0);
  endtask

  initial begin
    logic [127:0] key, kmask;
    logic [63:0]  pt, pmask;
    int id, n, m;

    // Reset state
    reset = 1'b0;
    tick(); tick();
    check("reset_outputs", 64'({co_w, vl_w, by_w}), 64'd0);
    #2 reset = 1'b1;
    tick();

    // Simon32/64 KAT, with over-long shift-in on key and plaintext
    load(0, {16'(($urandom)), 64'h1918111009080100}, 80, {8'(($urandom)), 32'h65656877}, 40);
    run_op(0, 1'b0, 1'b0, 1'b0, 1'b0, 64'hc69be9bb, "kat32");

    // Debug stream: top two key words
    run_op(0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h19181110, "debug32");

    // Busy immunity, then back-to-back re-encryption of the ciphertext
    load(0, 160'h0, 0, 64'h65656877, 32);
    run_op(0, 1'b0, 1'b1, 1'b0, 1'b1, 64'hc69be9bb, "busy_imm");
    run_op(0, 1'b0, 1'b0, 1'b1, 1'b0,
           simon_model(16, 4, 32, Z0, 128'h1918111009080100, 64'hc69be9bb), "b2b");

    // Locked key: key loads ignored, zero key used
    load(1, {64{1'b1}}, 64, 64'h65656877, 32);
    run_op(1, 1'b0, 1'b0, 1'b0, 1'b0, simon_model(16, 4, 32, Z0, 128'h0, 64'h65656877), "lock");
    run_op(1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, "lock_dbg");

    // Other word sizes
    load(2, 160'h1211100a0908020100, 72, 64'h6120676e696c, 48);
    run_op(2, 1'b0, 1'b0, 1'b0, 1'b0, 64'hdae5ac292cac, "kat48");
    load(3, 160'h1b1a1918131211100b0a090803020100, 128, 64'h656b696c20646e75, 64);
    run_op(3, 1'b0, 1'b0, 1'b0, 1'b0, 64'h44c8fc20b9dfa07a, "kat64");

    // Random keys and plaintexts against the reference model
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 3; j++) begin
        id = (j == 0) ? 0 : ((j == 1) ? 2 : 3);
        n = nn[id]; m = mm[id];
        kmask = (m * n == 128) ? '1 : ((128'd1 << (m * n)) - 128'd1);
        pmask = (n == 32) ? '1 : ((64'd1 << (2 * n)) - 64'd1);
        key = {$urandom, $urandom, $urandom, $urandom} & kmask;
        pt  = {$urandom, $urandom} & pmask;
        load(id, 160'(key), m * n, pt, 2 * n);
        run_op(id, 1'b0, 1'b0, 1'b0, 1'b0, simon_model(n, m, tt[id], (id == 3) ? Z3 : Z0, key, pt),
               $sformatf("rand%0d_%0d", r, id));
      end
    end

    // Reset at round 10
    load(0, 160'hffff_0000_aaaa_5555, 64, 64'h1234abcd, 32);
    sel = 0; data_rdy = 2'b11;
    tick();
    data_rdy = 2'b00;
    for (int c = 0; c < 10; c++) tick();
    check("mid_run_busy", 64'(by_w[0]), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_run_reset", 64'({co_w[0], vl_w[0], by_w[0]}), 64'd0);
    #1 reset = 1'b1;
    tick();
    run_op(0, 1'b0, 1'b0, 1'b0, 1'b0, simon_model(16, 4, 32, Z0, 128'h0, 64'h0), "post_rst");
    run_op(0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, "post_rst_dbg");

    // Reset while streaming output
    load(0, 160'h0, 0, 64'hffffffff, 32);
    data_rdy = 2'b11;
    tick();
    data_rdy = 2'b00;
    for (int c = 0; c < 36; c++) tick();
    check("mid_out_valid", 64'(vl_w[0]), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_out_reset", 64'({co_w[0], vl_w[0], by_w[0]}), 64'd0);
    #1 reset = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/simon_serial_core.md
Name: simon_serial_core

Overview:
- Parametrised bit-serial-I/O SIMON block encryptor (2N-bit block, M*N-bit key, T rounds).
- Computes one full round plus one key-schedule step per clock.
- Successor to the fixed-zero-key 32/64 top: loadable or locked key, configurable word size and key words, explicit busy, latched debug stream.
- Sits between the serial pad interface and chip top; same data_in/data_rdy/cipher_out/valid/debug_port pin protocol.

Parameters:
- N, 16, word size in bits (legal: 16, 24, 32).
- M, 4, key words (legal: 2, 3, 4).
- T, 32, round count (legal: 2..127).
- Z_SEQ, 62'b11111010001001010110000111001101111101000100101011000011100110, z constant sequence; bit 61 is z[0].
- KEY_LOCK, 0, 1 = key-load commands ignored and master key held at KEY_INIT.
- KEY_INIT, {M*N{1'b0}}, master key value after reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- data_in  in  1  serial plaintext/key bit.
- data_rdy  in  2  command: 00 idle, 01 shift plaintext bit, 10 shift key bit, 11 start.
- debug_port  in  1  sampled at start; 1 = output phase streams key instead of ciphertext.
- cipher_out  out  1  serial output bit.
- valid  out  1  high for each cipher_out bit of the output phase.
- busy  out  1  high in RUN and OUT.

Behaviour:
- Registers:
  - blk[2N-1:0] = {x,y}.
  - mkey[M*N-1:0] = {k[M-1]..k[0]}.
  - wkey: M words, working key-schedule window.
  - rcnt: 7 bits.
  - ocnt: log2(2N) bits.
  - dbg: 1 bit.
- Reset (reset=0, async): state=IDLE; blk=0; mkey=KEY_INIT; wkey=0; rcnt=0; ocnt=0; dbg=0; cipher_out=0; valid=0; busy=0.
- IDLE:
  - 01: blk <= {blk[2N-2:0], data_in}, MSB-first; the first bit sent ends up as x[N-1].
  - 10: if KEY_LOCK=0, mkey <= {mkey[M*N-2:0], data_in}, MSB-first, k[M-1] sent first. If KEY_LOCK=1, no effect.
  - 11: wkey <= mkey; dbg <= debug_port; rcnt <= 0; goto RUN.
  - 00: hold.
- RUN, one round per cycle using k = wkey word 0:
  - x' = y ^ ((x<<<1) & (x<<<8)) ^ (x<<<2) ^ k; y' = x. Rotates are modulo N.
  - Key step, rotates right:
    - M=4: tmp = (w3>>>3) ^ w1.
    - M=2 or 3: tmp = w[M-1]>>>3.
    - Then tmp ^= tmp>>>1.
    - new = ~w0 ^ tmp ^ z[rcnt mod 62] ^ 3.
    - Window shifts down: w0 <= w1 ... w[M-1] <= new.
  - rcnt increments. After the round with rcnt=T-1, goto OUT with ocnt=0.
  - Total RUN cycles = T.
- OUT: 2N cycles, valid=1.
  - dbg=0: cipher_out = blk[2N-1]; blk rotates left by 1 each cycle, so blk holds the ciphertext again at exit.
  - dbg=1: cipher_out = mkey[M*N-1-ocnt], i.e. k[M-1],k[M-2] MSB-first. blk rotates as for dbg=0.
  - After ocnt=2N-1, goto IDLE.
- cipher_out and valid are registered, so they change only on clk edges. cipher_out=0 whenever valid=0.
- Latency: start edge to first valid bit = T+1 cycles; last valid bit at T+2N after the start edge.
- Commands while busy=1 (01/10/11) are ignored; plaintext and key are not corrupted.
- Back-to-back: a start issued in the first IDLE cycle after OUT is accepted and re-encrypts the current blk, i.e. the previous ciphertext.
- debug_port changes during RUN/OUT have no effect.
- Reset asserted mid-RUN/OUT: immediate return to IDLE with all reset values. Output drops the same instant, valid=0.
- Over-long shift-in: extra bits shift older bits out of the MSB; only the last 2N (or M*N) bits are retained.

Test Plan:
- Simon32/64 KAT (defaults): shift key 0x1918111009080100, plaintext 0x65656877, start, debug_port=0 -> busy 32+32 cycles; valid for 32 cycles beginning 33 cycles after the start edge; streamed bits = 0xc69be9bb MSB-first.
- Debug: same loads, start with debug_port=1, debug_port dropped after 1 cycle -> valid stream = 0x19181110.
- KEY_LOCK=1, KEY_INIT=0: send 64 key bits of all ones, then plaintext 0x65656877, start. Expected: output equals the golden-model ciphertext under the zero key, and the debug stream = 0x00000000.
- Busy immunity: during RUN issue data_rdy=01 with data_in=1 for 10 cycles and data_rdy=10 for 10 cycles -> ciphertext still 0xc69be9bb; a second start in IDLE re-encrypts 0xc69be9bb (golden model).
- Reset mid-operation: assert reset at round 10 -> cipher_out=0, valid=0, busy=0 asynchronously; after release, mkey=KEY_INIT and blk=0.
- Parameter sweep N=24/M=3/T=36 and N=32/M=4/T=44 with the matching z sequences: published KATs match, and valid lasts 48/64 cycles.
